// File: rtl/button_filter.sv
// button_filter: multi-channel button debouncer with edge detection and typematic repeat.
//   A shared prescaler produces one sample tick every 2^DIV_BITS clocks. Each channel flips
//   its debounced level only after SAMPLES consecutive differing samples. Each channel also
//   emits edge pulses and a press strobe that auto-repeats while the button is held.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   raw        raw button levels, already synchronised upstream
//   debounced  filtered level (registered)
//   pos_edge   one-cycle pulse when debounced rises
//   neg_edge   one-cycle pulse when debounced falls
//   press      one-cycle pulse on a rising edge and on each auto-repeat
module button_filter #(
  parameter int unsigned      WIDTH        = 6,
  parameter int unsigned      DIV_BITS     = 18,
  parameter int unsigned      SAMPLES      = 2,
  parameter int unsigned      REPEAT_DELAY = 16,
  parameter int unsigned      REPEAT_RATE  = 4,
  parameter logic [WIDTH-1:0] REPEAT_MASK  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] press
);

  localparam int unsigned AW   = $clog2(SAMPLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [DIV_BITS-1:0] presc;
  logic                tick_c;

  logic [AW-1:0]       agree     [WIDTH];
  logic [AW-1:0]       agree_nxt [WIDTH];
  logic [RW-1:0]       rpt       [WIDTH];
  logic [RW-1:0]       rpt_nxt   [WIDTH];
  logic [WIDTH-1:0]    deb_nxt;
  logic [WIDTH-1:0]    pos_nxt;
  logic [WIDTH-1:0]    neg_nxt;
  logic [WIDTH-1:0]    press_nxt;
  logic [WIDTH-1:0]    flip_c;

  // Free-running sample prescaler; tick when it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_BITS'(1);
    end
  end

  assign tick_c = (presc == '0);

  // Per-channel agreement filter and repeat timer; pulse outputs idle at 0 between ticks.
  always_comb begin
    deb_nxt   = debounced;
    pos_nxt   = '0;
    neg_nxt   = '0;
    press_nxt = '0;
    flip_c    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      agree_nxt[i] = agree[i];
      rpt_nxt[i]   = rpt[i];
    end
    if (tick_c) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (raw[i] == debounced[i]) begin
          agree_nxt[i] = '0;
        end else if (agree[i] == AW'(SAMPLES - 1)) begin
          flip_c[i]    = 1'b1;
          agree_nxt[i] = '0;
        end else begin
          agree_nxt[i] = agree[i] + AW'(1);
        end

        // A flip takes priority over any repeat that would otherwise fall due this tick.
        if (flip_c[i]) begin
          deb_nxt[i] = ~debounced[i];
          if (!debounced[i]) begin
            pos_nxt[i]   = 1'b1;
            press_nxt[i] = 1'b1;
            rpt_nxt[i]   = RW'(REPEAT_DELAY);
          end else begin
            neg_nxt[i]   = 1'b1;
            rpt_nxt[i]   = '0;
          end
        end else if (debounced[i] && REPEAT_MASK[i]) begin
          if (rpt[i] == RW'(1)) begin
            press_nxt[i] = 1'b1;
            rpt_nxt[i]   = RW'(REPEAT_RATE);
          end else begin
            rpt_nxt[i]   = rpt[i] - RW'(1);
          end
        end
      end
    end
  end

  // Output and per-channel counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debounced <= '0;
      pos_edge  <= '0;
      neg_edge  <= '0;
      press     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        agree[i] <= '0;
        rpt[i]   <= '0;
      end
    end else begin
      debounced <= deb_nxt;
      pos_edge  <= pos_nxt;
      neg_edge  <= neg_nxt;
      press     <= press_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        agree[i] <= agree_nxt[i];
        rpt[i]   <= rpt_nxt[i];
      end
    end
  end

endmodule

// File: doc/button_filter.md
Name: button_filter

Overview:
- Parametrised successor to the six-button debouncer: WIDTH independent channels, shared sample prescaler, N-consecutive-sample agreement filter.
- Per channel: debounced level, rising/falling edge pulses and a "press" strobe with typematic auto-repeat for held buttons.
- Sits between the raw pad inputs and the game/keyboard controller. The controller consumes press for cursor/letter stepping and pos_edge/neg_edge for one-shot actions.

Parameters:
- WIDTH, 6, number of input channels.
- DIV_BITS, 18, prescaler width; one sample tick every 2^DIV_BITS clocks. Legal range 1..24.
- SAMPLES, 2, consecutive disagreeing samples needed to flip debounced. Legal range 1..15.
- REPEAT_DELAY, 16, ticks from a press edge to the first auto-repeat. Must be >= 1.
- REPEAT_RATE, 4, ticks between subsequent auto-repeats. Must be >= 1.
- REPEAT_MASK, {WIDTH{1'b1}}, per-channel auto-repeat enable.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- raw  input  WIDTH  raw button levels; the block assumes they are already synchronised upstream.
- debounced  output  WIDTH  filtered level, registered.
- pos_edge  output  WIDTH  one-cycle pulse when debounced goes 0->1.
- neg_edge  output  WIDTH  one-cycle pulse when debounced goes 1->0.
- press  output  WIDTH  one-cycle pulse on pos_edge and on each auto-repeat.

Behaviour:
- Reset: rst is asynchronous and active-high. It clears the prescaler, debounced, pos_edge, neg_edge, press and all per-channel agreement and repeat counters to 0, at any time including mid-count.
- Prescaler: DIV_BITS-bit free-running up-counter that wraps 2^DIV_BITS-1 -> 0.
  - tick = (prescaler == 0), decoded combinationally.
  - The first tick is the first clock edge after rst deasserts.
- Outputs are registered. Effects of a tick appear on the clock edge at which tick=1 is sampled.
- Pulse outputs are 0 on every non-tick cycle and are never high for more than one cycle.
- Agreement filter, per channel i, width clog2(SAMPLES+1), on tick:
  - raw[i] == debounced[i]: agree[i] <= 0.
  - raw[i] != debounced[i] and agree[i] == SAMPLES-1: debounced[i] flips, agree[i] <= 0, and pos_edge[i] or neg_edge[i] fires as appropriate.
  - otherwise: agree[i] <= agree[i]+1.
  - SAMPLES=1 means every differing sample flips immediately.
- Auto-repeat, per channel, rpt counter of width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - On the tick where debounced rises: press[i]=1 and rpt[i] <= REPEAT_DELAY.
  - On a later tick with debounced[i]=1 and REPEAT_MASK[i]=1:
    - if rpt[i]==1: press[i]=1 and rpt[i] <= REPEAT_RATE;
    - else rpt[i] <= rpt[i]-1.
  - On the tick where debounced falls: rpt[i] <= 0 and no press.
  - Masked channels: press equals pos_edge.
- Channels are fully independent. Any number of channels may flip or repeat on the same tick.
- A raw change in the middle of an agreement count that returns to the debounced level resets agree[i] to 0 on that tick. There is no partial credit across glitches.

Test Plan:
Bench parameters for all scenarios: DIV_BITS=2 (tick every 4 clocks), SAMPLES=3, REPEAT_DELAY=3, REPEAT_RATE=2, REPEAT_MASK=6'b111101.
1. Reset/idle: rst pulsed asynchronously between clock edges with raw=0 -> all outputs 0 immediately; with raw=0 for 40 clocks they stay 0. First tick occurs on the first edge after release.
2. Clean press: raw[0]=1 held before tick T0 -> debounced[0] rises at T2 (third differing sample). pos_edge[0]=press[0]=1 for exactly one cycle; no other bits move.
3. Glitch rejection: raw[2]=1 for ticks T0,T1, then 0 at T2, then 1 at T3,T4,T5 -> debounced[2] rises at T5, not T3. No edge pulses before T5.
4. Auto-repeat: raw[0] held high from the press at Tp -> press[0] pulses at Tp, Tp+3, Tp+5, Tp+7. Releasing raw at Tr -> neg_edge[0] pulses at Tr+2 and press stops.
5. Masked channel: raw[1] held 12 ticks -> press[1] pulses only at its rising-edge tick; pos_edge[1] once, no repeats.
6. Simultaneous events with reset mid-operation: raw=6'b110001 applied together -> bits 0,4,5 all get pos_edge and press on the same tick. Asserting rst while channel 0 is mid-repeat -> all outputs 0. After release with raw still high, debounced re-rises after 3 ticks and the repeat timing restarts from REPEAT_DELAY.
